// File: rtl/tt_bist_harness.sv
// BIST harness for Tiny Tapeout user designs: an LFSR drives the DUT inputs and a MISR
// compacts the DUT outputs into a signature, which is compared against a golden value.
module tt_bist_harness #(
  parameter int unsigned       IN_W       = 8,
  parameter int unsigned       OUT_W      = 8,
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned       SIG_W      = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY   = 16'h1021,
  parameter int unsigned       NUM_VEC    = 256,
  parameter int unsigned       SETTLE_CYC = 1,
  parameter logic [SIG_W-1:0]  GOLDEN     = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      vec_count,
  output logic [SIG_W-1:0] signature,
  output logic [IN_W-1:0]  dut_ui,
  output logic [IN_W-1:0]  dut_uio_in,
  input  logic [OUT_W-1:0] dut_uo,
  input  logic [OUT_W-1:0] dut_uio_out,
  input  logic [OUT_W-1:0] dut_uio_oe
);

  localparam int unsigned OBS_W  = 3 * OUT_W;
  localparam int unsigned NSLICE = (OBS_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W  = NSLICE * SIG_W;

  localparam logic [LFSR_W-1:0] SEED_EFF    = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  localparam logic [15:0]       NUM_VEC_L   = 16'(NUM_VEC);
  localparam logic [7:0]        SETTLE_LAST = 8'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction

  // Zero-pad the observation word to whole signature slices and XOR the slices together.
  function automatic logic [SIG_W-1:0] fold_obs(input logic [OBS_W-1:0] obs);
    logic [PAD_W-1:0] pad;
    logic [SIG_W-1:0] acc;
    pad = PAD_W'(obs);
    acc = '0;
    for (int i = 0; i < NSLICE; i++) begin
      acc = acc ^ pad[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] fold);
    return (sig << 1) ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ fold;
  endfunction

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       vec_count_q, vec_count_d;
  logic [SIG_W-1:0]  signature_q, signature_d;
  logic [IN_W-1:0]   dut_ui_q, dut_ui_d;
  logic [IN_W-1:0]   dut_uio_in_q, dut_uio_in_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;

  logic [OBS_W-1:0]  obs;
  logic [SIG_W-1:0]  misr_next;
  logic [15:0]       vec_inc;

  // Undriven uio pins (oe low) are masked so floating values never reach the signature.
  assign obs       = {dut_uio_oe, dut_uio_out & dut_uio_oe, dut_uo};
  assign misr_next = misr_step(signature_q, fold_obs(obs));
  assign vec_inc   = vec_count_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    vec_count_d  = vec_count_q;
    signature_d  = signature_q;
    dut_ui_d     = dut_ui_q;
    dut_uio_in_d = dut_uio_in_q;
    lfsr_d       = lfsr_q;
    settle_cnt_d = settle_cnt_q;

    if (abort) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      dut_ui_d     = '0;
      dut_uio_in_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_APPLY;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            lfsr_d      = SEED_EFF;
            signature_d = '0;
            vec_count_d = '0;
          end
        end
        S_APPLY: begin
          dut_ui_d     = lfsr_q[IN_W-1:0];
          dut_uio_in_d = lfsr_q[2*IN_W-1:IN_W];
          settle_cnt_d = '0;
          state_d      = (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        S_CAPTURE: begin
          signature_d = misr_next;
          vec_count_d = vec_inc;
          lfsr_d      = lfsr_step(lfsr_q);
          if (vec_inc == NUM_VEC_L) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_next == GOLDEN);
          end else begin
            state_d = S_APPLY;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      vec_count_q  <= '0;
      signature_q  <= '0;
      dut_ui_q     <= '0;
      dut_uio_in_q <= '0;
      lfsr_q       <= LFSR_SEED;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      vec_count_q  <= vec_count_d;
      signature_q  <= signature_d;
      dut_ui_q     <= dut_ui_d;
      dut_uio_in_q <= dut_uio_in_d;
      lfsr_q       <= lfsr_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign vec_count  = vec_count_q;
  assign signature  = signature_q;
  assign dut_ui     = dut_ui_q;
  assign dut_uio_in = dut_uio_in_q;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed bench for tt_bist_harness: three harness instances with different run lengths,
// each looped back through a trivial DUT model (uo = ui, optionally with one bit flipped).
module tb_tt_bist_harness;

  logic clk;
  int   compared;
  int   mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: one vector, one settle cycle, golden matches the clean single-vector signature.
  logic        rst_a, start_a, abort_a, busy_a, done_a, pass_a;
  logic [15:0] vc_a, sig_a;
  logic [7:0]  ui_a, uioi_a, uo_a, uout_a, oe_a, flip_a;
  assign uo_a = ui_a ^ flip_a;

  tt_bist_harness #(.NUM_VEC(1), .SETTLE_CYC(1), .GOLDEN(16'h00E1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .vec_count(vc_a), .signature(sig_a),
    .dut_ui(ui_a), .dut_uio_in(uioi_a),
    .dut_uo(uo_a), .dut_uio_out(uout_a), .dut_uio_oe(oe_a)
  );

  // Instance B: four vectors, two settle cycles.
  logic        rst_b, start_b, abort_b, busy_b, done_b, pass_b;
  logic [15:0] vc_b, sig_b;
  logic [7:0]  ui_b, uioi_b, uo_b;
  assign uo_b = ui_b;

  tt_bist_harness #(.NUM_VEC(4), .SETTLE_CYC(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .vec_count(vc_b), .signature(sig_b),
    .dut_ui(ui_b), .dut_uio_in(uioi_b),
    .dut_uo(uo_b), .dut_uio_out(8'h00), .dut_uio_oe(8'h00)
  );

  // Instance C: default 256-vector run.
  logic        rst_c, start_c, abort_c, busy_c, done_c, pass_c;
  logic [15:0] vc_c, sig_c;
  logic [7:0]  ui_c, uioi_c, uo_c;
  assign uo_c = ui_c;

  tt_bist_harness #(.NUM_VEC(256), .SETTLE_CYC(1)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .abort(abort_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .vec_count(vc_c), .signature(sig_c),
    .dut_ui(ui_c), .dut_uio_in(uioi_c),
    .dut_uo(uo_c), .dut_uio_out(8'h00), .dut_uio_oe(8'h00)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signature of an n-vector run for 8-bit pins, LFSR seed ACE1, uo = ui ^ flip.
  function automatic logic [15:0] model_sig(input int n, input logic [7:0] flip,
                                            input logic [7:0] uout, input logic [7:0] oe);
    logic [15:0] lf, sg, fd;
    logic [23:0] ob;
    lf = 16'hACE1;
    sg = 16'h0000;
    for (int k = 0; k < n; k++) begin
      ob = {oe, uout & oe, lf[7:0] ^ flip};
      fd = ob[15:0] ^ {8'h00, ob[23:16]};
      sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0000) ^ fd;
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    return sg;
  endfunction

  task automatic run_a(input string tag);
    int i;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    i = 0;
    while (!done_a && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, {31'd0, done_a}, 32'd1);
  endtask

  task automatic wait_vc_c(input logic [15:0] target, input string tag);
    int i;
    i = 0;
    while (vc_c != target && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_reach"}, {16'd0, vc_c}, {16'd0, target});
  endtask

  task automatic wait_done_c(input string tag);
    int i;
    i = 0;
    while (!done_c && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, {31'd0, done_c}, 32'd1);
  endtask

  initial begin
    int busy_cnt;
    logic [15:0] exp_sig;
    compared   = 0;
    mismatched = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
    uout_a = 8'h00; oe_a = 8'h00; flip_a = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, busy_c}, 32'd0);
    chk("rst_done", {31'd0, done_c}, 32'd0);
    chk("rst_pass", {31'd0, pass_c}, 32'd0);
    chk("rst_vc", {16'd0, vc_c}, 32'd0);
    chk("rst_sig", {16'd0, sig_c}, 32'd0);
    chk("rst_ui", {24'd0, ui_c}, 32'd0);
    chk("rst_uioin", {24'd0, uioi_c}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);

    // Single vector: APPLY drives the seed bytes, signature is the folded uo byte.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("t1_busy", {31'd0, busy_a}, 32'd1);
    chk("t1_done_low", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    chk("t1_ui", {24'd0, ui_a}, 32'h00E1);
    chk("t1_uioin", {24'd0, uioi_a}, 32'h00AC);
    begin : t1_wait
      int i;
      i = 0;
      while (!done_a && i < 50) begin
        @(negedge clk);
        i++;
      end
    end
    chk("t1_done", {31'd0, done_a}, 32'd1);
    chk("t1_sig", {16'd0, sig_a}, 32'h00E1);
    chk("t1_vc", {16'd0, vc_a}, 32'd1);
    chk("t4_pass", {31'd0, pass_a}, 32'd1);
    chk("t1_busy_end", {31'd0, busy_a}, 32'd0);

    // uio_out contributes only where oe is high.
    uout_a = 8'hFF; oe_a = 8'h0F;
    run_a("t2a");
    chk("t2_sig_oe0f", {16'd0, sig_a}, 32'h0FEE);
    chk("t2_pass_oe0f", {31'd0, pass_a}, 32'd0);
    oe_a = 8'h00;
    run_a("t2b");
    chk("t2_sig_oe00", {16'd0, sig_a}, 32'h00E1);
    uout_a = 8'h00;

    // A single flipped output bit changes the signature and clears pass.
    flip_a = 8'h01;
    run_a("t4");
    chk("t4_sig_flip", {16'd0, sig_a}, 32'h00E0);
    chk("t4_pass_flip", {31'd0, pass_a}, 32'd0);
    flip_a = 8'h00;

    // Four vectors with two settle cycles: busy lasts 4*(2+2) cycles.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("t3_done_low", {31'd0, done_b}, 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy_b; i++) begin
      busy_cnt++;
      @(negedge clk);
    end
    chk("t3_busy_cycles", busy_cnt, 32'd16);
    chk("t3_done_rise", {31'd0, done_b}, 32'd1);
    chk("t3_vc", {16'd0, vc_b}, 32'd4);
    exp_sig = model_sig(4, 8'h00, 8'h00, 8'h00);
    chk("t3_sig", {16'd0, sig_b}, {16'd0, exp_sig});

    // start while busy is ignored; abort leaves signature and count intact.
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_vc_c(16'd10, "t5_v10");
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("t5_start_ignored_vc", {16'd0, vc_c}, 32'd10);
    chk("t5_start_ignored_busy", {31'd0, busy_c}, 32'd1);
    wait_vc_c(16'd20, "t5_v20");
    abort_c = 1'b1;
    @(negedge clk);
    abort_c = 1'b0;
    chk("t5_abort_busy", {31'd0, busy_c}, 32'd0);
    chk("t5_abort_done", {31'd0, done_c}, 32'd0);
    chk("t5_abort_ui", {24'd0, ui_c}, 32'd0);
    chk("t5_abort_uioin", {24'd0, uioi_c}, 32'd0);
    chk("t5_abort_vc", {16'd0, vc_c}, 32'd20);
    exp_sig = model_sig(20, 8'h00, 8'h00, 8'h00);
    chk("t5_abort_sig", {16'd0, sig_c}, {16'd0, exp_sig});
    repeat (3) @(negedge clk);
    chk("t5_idle_stays", {31'd0, busy_c}, 32'd0);

    // start and abort together: abort wins.
    start_c = 1'b1; abort_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0; abort_c = 1'b0;
    chk("t5_abort_wins_busy", {31'd0, busy_c}, 32'd0);
    chk("t5_abort_wins_vc", {16'd0, vc_c}, 32'd20);

    // Reset mid-run, then a clean full run.
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_vc_c(16'd30, "t6_v30");
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    chk("t6_rst_busy", {31'd0, busy_c}, 32'd0);
    chk("t6_rst_done", {31'd0, done_c}, 32'd0);
    chk("t6_rst_pass", {31'd0, pass_c}, 32'd0);
    chk("t6_rst_vc", {16'd0, vc_c}, 32'd0);
    chk("t6_rst_sig", {16'd0, sig_c}, 32'd0);
    chk("t6_rst_ui", {24'd0, ui_c}, 32'd0);
    chk("t6_rst_uioin", {24'd0, uioi_c}, 32'd0);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_done_c("t6_run");
    exp_sig = model_sig(256, 8'h00, 8'h00, 8'h00);
    chk("t6_sig", {16'd0, sig_c}, {16'd0, exp_sig});
    chk("t6_vc", {16'd0, vc_c}, 32'd256);
    chk("t6_pass", {31'd0, pass_c}, {31'd0, (exp_sig == 16'h0000)});
    chk("t6_ui_hold", {24'd0, ui_c}, {24'd0, ui_c ^ uo_c ^ ui_c});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
